sseg_scan_decoder: RTL and testbench

// - Receive side of the multiplexed 7-segment interface: watches sevenseg/anode as driven by the display scanner
//   and rebuilds the 4-digit, 16-bit hex value shown on the display.
// - Used for on-board loopback self-check of the ALU display path and as a bench monitor; sits beside the display block.

---
 rtl/sseg_dec_defs.sv | 29 ++
 rtl/sseg_pattern_decode.sv | 39 +++
 rtl/sseg_scan_decoder.sv | 198 +++++++++++++++++++
 tb/tb_sseg_scan_decoder.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/sseg_dec_defs.sv
// Shared definitions for the 7-segment scan decoder: FSM state encoding and
// the active-low segment patterns (index 0 = segment a) for hex digits and blank.
package sseg_dec_defs;

   typedef enum logic [1:0] {
      ST_WAIT   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_HOLD   = 2'd2
   } state_t;

   localparam logic [0:6] SEG_0     = 7'b0000001;
   localparam logic [0:6] SEG_1     = 7'b1001111;
   localparam logic [0:6] SEG_2     = 7'b0010010;
   localparam logic [0:6] SEG_3     = 7'b0000110;
   localparam logic [0:6] SEG_4     = 7'b1001100;
   localparam logic [0:6] SEG_5     = 7'b0100100;
   localparam logic [0:6] SEG_6     = 7'b0100000;
   localparam logic [0:6] SEG_7     = 7'b0001111;
   localparam logic [0:6] SEG_8     = 7'b0000000;
   localparam logic [0:6] SEG_9     = 7'b0000100;
   localparam logic [0:6] SEG_A     = 7'b0001000;
   localparam logic [0:6] SEG_B     = 7'b1100000;
   localparam logic [0:6] SEG_C     = 7'b0110001;
   localparam logic [0:6] SEG_D     = 7'b1000010;
   localparam logic [0:6] SEG_E     = 7'b0110000;
   localparam logic [0:6] SEG_F     = 7'b0111000;
   localparam logic [0:6] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/sseg_pattern_decode.sv
// Combinational segment-pattern decoder: active-low 7-bit pattern to hex nibble.
// Blank yields nibble 0 with blank set; any non-hex pattern yields nibble 0 with err set.
module sseg_pattern_decode
   import sseg_dec_defs::*;
(
   input  logic [0:6] seg,
   output logic [3:0] nibble,
   output logic       blank,
   output logic       err
);

   // Pattern lookup against the shared segment table
   always_comb begin
      nibble = 4'h0;
      blank  = 1'b0;
      err    = 1'b0;
      case (seg)
         SEG_0:     nibble = 4'h0;
         SEG_1:     nibble = 4'h1;
         SEG_2:     nibble = 4'h2;
         SEG_3:     nibble = 4'h3;
         SEG_4:     nibble = 4'h4;
         SEG_5:     nibble = 4'h5;
         SEG_6:     nibble = 4'h6;
         SEG_7:     nibble = 4'h7;
         SEG_8:     nibble = 4'h8;
         SEG_9:     nibble = 4'h9;
         SEG_A:     nibble = 4'hA;
         SEG_B:     nibble = 4'hB;
         SEG_C:     nibble = 4'hC;
         SEG_D:     nibble = 4'hD;
         SEG_E:     nibble = 4'hE;
         SEG_F:     nibble = 4'hF;
         SEG_BLANK: blank  = 1'b1;
         default:   err    = 1'b1;
      endcase
   end

endmodule

// File: rtl/sseg_scan_decoder.sv
// Receive side of a multiplexed 4-digit 7-segment display: rebuilds the shown
// 16-bit hex value from sevenseg/anode. A digit is captured once per anode dwell
// after SETTLE_CYCLES of stable inputs; num is published after FRAMES_STABLE
// identical error-free frames. Define SSEG_DEC_SYNC_EN to pass the inputs through
// 2-FF synchronizers (adds 2 cycles of latency); otherwise inputs are used directly.
module sseg_scan_decoder
   import sseg_dec_defs::*;
#(
   parameter int SETTLE_CYCLES  = 4,
   parameter int FRAMES_STABLE  = 2,
   parameter int TIMEOUT_CYCLES = 1048576
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [0:6]  sevenseg,
   input  logic [3:0]  anode,
   output logic [15:0] num,
   output logic        num_valid,
   output logic [3:0]  digit_err,
   output logic        stale
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [0:6]    seg_in;
   logic [3:0]    an_in;

`ifdef SSEG_DEC_SYNC_EN
   logic [0:6]    seg_p0, seg_p1;
   logic [3:0]    an_p0, an_p1;

   // Two-flop synchronizers; reset to the idle (all segments off, no digit) level
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg_p0 <= '1;
         seg_p1 <= '1;
         an_p0  <= '1;
         an_p1  <= '1;
      end else begin
         seg_p0 <= sevenseg;
         seg_p1 <= seg_p0;
         an_p0  <= anode;
         an_p1  <= an_p0;
      end
   end

   assign seg_in = seg_p1;
   assign an_in  = an_p1;
`else
   assign seg_in = sevenseg;
   assign an_in  = anode;
`endif

   state_t        state, state_nxt;
   logic [7:0]    settle_cnt;
   logic [0:6]    prev_seg;
   logic [3:0]    prev_an;
   logic          sel;
   logic [1:0]    idx;
   logic          capture;
   logic          an_changed, changed;

   logic [3:0]    dec_nib;
   logic          dec_blank, dec_err;
   logic [3:0]    cap_nib;

   logic [15:0]   frame, prev_frame;
   logic [3:0]    seen, err_r;
   logic [3:0]    stable_cnt, stable_nxt;
   logic          have_num;
   logic [TW-1:0] tcnt;
   logic          complete, publish, expire;

   sseg_pattern_decode u_dec (
      .seg    (seg_in),
      .nibble (dec_nib),
      .blank  (dec_blank),
      .err    (dec_err)
   );

   assign cap_nib = (dec_blank || dec_err) ? 4'h0 : dec_nib;

   // Digit select: exactly one anode low, anything else selects nothing
   always_comb begin
      sel = 1'b1;
      idx = 2'd0;
      case (an_in)
         4'b1110: idx = 2'd0;
         4'b1101: idx = 2'd1;
         4'b1011: idx = 2'd2;
         4'b0111: idx = 2'd3;
         default: sel = 1'b0;
      endcase
   end

   assign an_changed = (an_in != prev_an);
   assign changed    = an_changed || (seg_in != prev_seg);

   // FSM next state and capture strobe
   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      case (state)
         ST_WAIT: begin
            if (sel) state_nxt = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (changed || !sel) begin
               state_nxt = ST_WAIT;
            end else if (int'(settle_cnt) + 1 >= SETTLE_CYCLES) begin
               capture   = 1'b1;
               state_nxt = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (an_changed) state_nxt = ST_WAIT;
         end
         default: state_nxt = ST_WAIT;
      endcase
   end

   // FSM state, settle counter and previous-input history for change detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_WAIT;
         settle_cnt <= 8'd0;
         prev_seg   <= '1;
         prev_an    <= '1;
      end else begin
         state    <= state_nxt;
         prev_seg <= seg_in;
         prev_an  <= an_in;
         if (state == ST_SETTLE && state_nxt == ST_SETTLE)
            settle_cnt <= settle_cnt + 8'd1;
         else
            settle_cnt <= 8'd0;
      end
   end

   assign complete   = (seen == 4'hF);
   assign stable_nxt = (frame != prev_frame) ? 4'd1 :
                       (stable_cnt == 4'hF)  ? 4'hF : stable_cnt + 4'd1;
   assign publish    = complete && (err_r == 4'h0) &&
                       (int'(stable_nxt) >= FRAMES_STABLE) &&
                       ((frame != num) || !have_num);
   assign expire     = !capture && (tcnt == T_LAST);

   // Frame assembly, stability tracking, publication and staleness timeout
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame      <= 16'h0;
         prev_frame <= 16'h0;
         seen       <= 4'h0;
         err_r      <= 4'h0;
         stable_cnt <= 4'h0;
         have_num   <= 1'b0;
         tcnt       <= '0;
         num        <= 16'h0;
         num_valid  <= 1'b0;
         digit_err  <= 4'h0;
         stale      <= 1'b1;
      end else begin
         num_valid <= 1'b0;
         if (complete) begin
            seen      <= 4'h0;
            digit_err <= err_r;
            if (err_r != 4'h0) begin
               stable_cnt <= 4'h0;
            end else begin
               stable_cnt <= stable_nxt;
               prev_frame <= frame;
               if (publish) begin
                  num       <= frame;
                  num_valid <= 1'b1;
                  have_num  <= 1'b1;
               end
            end
         end
         if (capture) begin
            frame[{idx, 2'b00} +: 4] <= cap_nib;
            seen[idx]  <= 1'b1;
            err_r[idx] <= dec_err;
            tcnt       <= '0;
            stale      <= 1'b0;
         end else if (tcnt != T_MAX) begin
            tcnt <= tcnt + TW'(1);
            if (expire) begin
               stale      <= 1'b1;
               seen       <= 4'h0;
               stable_cnt <= 4'h0;
            end
         end
      end
   end

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Directed bench for sseg_scan_decoder: a behavioural scanner drives digit
// patterns; expected publications are queued and matched on each num_valid pulse.
module tb_sseg_scan_decoder;

   logic        clk = 1'b0;
   logic        rst;
   logic [0:6]  sevenseg;
   logic [3:0]  anode;
   logic [15:0] num;
   logic        num_valid;
   logic [3:0]  digit_err;
   logic        stale;

   int checks   = 0;
   int failures = 0;
   int pulses   = 0;
   logic [15:0] exp_q[$];

   sseg_scan_decoder #(
      .SETTLE_CYCLES  (4),
      .FRAMES_STABLE  (2),
      .TIMEOUT_CYCLES (300)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .sevenseg  (sevenseg),
      .anode     (anode),
      .num       (num),
      .num_valid (num_valid),
      .digit_err (digit_err),
      .stale     (stale)
   );

   always #5 clk = ~clk;

   function automatic logic [0:6] hex_seg(input logic [3:0] n);
      logic [0:6] p;
      case (n)
         4'h0: p = 7'b0000001;  4'h1: p = 7'b1001111;
         4'h2: p = 7'b0010010;  4'h3: p = 7'b0000110;
         4'h4: p = 7'b1001100;  4'h5: p = 7'b0100100;
         4'h6: p = 7'b0100000;  4'h7: p = 7'b0001111;
         4'h8: p = 7'b0000000;  4'h9: p = 7'b0000100;
         4'hA: p = 7'b0001000;  4'hB: p = 7'b1100000;
         4'hC: p = 7'b0110001;  4'hD: p = 7'b1000010;
         4'hE: p = 7'b0110000;  default: p = 7'b0111000;
      endcase
      return p;
   endfunction

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic show_digit(input logic [3:0] an, input logic [0:6] sg, input int dwell);
      anode    = an;
      sevenseg = sg;
      repeat (dwell) @(negedge clk);
   endtask

   // Scan digits first..last of val; blank_m digits shown blank, bad_m digits shown 1111110
   task automatic scan(input logic [15:0] val, input int first, input int last,
                       input int dwell, input logic [3:0] blank_m, input logic [3:0] bad_m);
      logic [0:6] p;
      for (int i = first; i <= last; i++) begin
         p = hex_seg(val[4*i +: 4]);
         if (blank_m[i]) p = 7'b1111111;
         if (bad_m[i])   p = 7'b1111110;
         show_digit(~(4'b0001 << i), p, dwell);
      end
   endtask

   // Scoreboard: every num_valid pulse must match the next queued value
   always @(negedge clk) begin
      if (num_valid === 1'b1) begin
         logic [15:0] e;
         pulses++;
         checks++;
         assert (exp_q.size() > 0) else begin
            failures++;
            $error("FAIL unexpected_num_valid observed num=%h expected no pulse", num);
         end
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            assert (num === e) else begin
               failures++;
               $error("FAIL published_num observed=%h expected=%h", num, e);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst      = 1'b1;
      anode    = 4'hF;
      sevenseg = 7'b1111111;
      repeat (3) @(negedge clk);
      check("rst_num",       num,               16'h0);
      check("rst_num_valid", {15'b0, num_valid}, 16'h0);
      check("rst_digit_err", {12'b0, digit_err}, 16'h0);
      check("rst_stale",     {15'b0, stale},     16'h1);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Basic scan of 0012: publishes once after the second frame, third frame is silent
      exp_q.push_back(16'h0012);
      repeat (3) scan(16'h0012, 0, 3, 8, 4'h0, 4'h0);
      check("basic_num",    num,                16'h0012);
      check("basic_stale",  {15'b0, stale},     16'h0);
      check("basic_err",    {12'b0, digit_err}, 16'h0);
      check("basic_pulses", 16'(pulses),        16'd1);

      // Value changes mid-frame: the mixed frame BE12 must never be published
      exp_q.push_back(16'hBEEF);
      scan(16'h0012, 0, 1, 8, 4'h0, 4'h0);
      scan(16'hBEEF, 2, 3, 8, 4'h0, 4'h0);
      repeat (2) scan(16'hBEEF, 0, 3, 8, 4'h0, 4'h0);
      check("beef_num",    num,         16'hBEEF);
      check("beef_pulses", 16'(pulses), 16'd2);

      // Unknown pattern on digit 2 flags the error and publishes nothing
      scan(16'hBEEF, 0, 3, 8, 4'h0, 4'b0100);
      check("bad_digit_err", {12'b0, digit_err}, 16'h0004);
      check("bad_num",       num,                16'hBEEF);
      scan(16'hBEEF, 0, 3, 8, 4'h0, 4'h0);
      check("bad_cleared",   {12'b0, digit_err}, 16'h0);

      // Blank digit decodes to 0 without error
      exp_q.push_back(16'h0EEF);
      repeat (2) scan(16'hBEEF, 0, 3, 8, 4'b1000, 4'h0);
      check("blank_num", num,                16'h0EEF);
      check("blank_err", {12'b0, digit_err}, 16'h0);

      // Two anodes low for a whole dwell are ignored
      exp_q.push_back(16'h1234);
      scan(16'h1234, 0, 1, 8, 4'h0, 4'h0);
      show_digit(4'b1100, hex_seg(4'h9), 8);
      scan(16'h1234, 2, 3, 8, 4'h0, 4'h0);
      scan(16'h1234, 0, 3, 8, 4'h0, 4'h0);
      check("multi_anode_num", num,         16'h1234);
      check("multi_pulses",    16'(pulses), 16'd4);

      // Dwell shorter than the settle time: no captures, stale after the timeout
      repeat (8) scan(16'h5678, 0, 3, 3, 4'h0, 4'h0);
      check("short_not_stale_yet", {15'b0, stale}, 16'h0);
      repeat (32) scan(16'h5678, 0, 3, 3, 4'h0, 4'h0);
      check("timeout_stale", {15'b0, stale}, 16'h1);
      check("timeout_num",   num,            16'h1234);
      scan(16'h1234, 0, 3, 8, 4'h0, 4'h0);
      check("recover_stale", {15'b0, stale}, 16'h0);

      // Asynchronous reset mid-frame, then a full stable sequence republishes
      scan(16'h5678, 0, 1, 8, 4'h0, 4'h0);
      anode    = 4'b1011;
      sevenseg = hex_seg(4'h6);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("midrst_num",       num,                16'h0);
      check("midrst_num_valid", {15'b0, num_valid}, 16'h0);
      check("midrst_digit_err", {12'b0, digit_err}, 16'h0);
      check("midrst_stale",     {15'b0, stale},     16'h1);
      @(negedge clk);
      rst = 1'b0;
      exp_q.push_back(16'h5678);
      scan(16'h5678, 2, 3, 8, 4'h0, 4'h0);
      repeat (2) scan(16'h5678, 0, 3, 8, 4'h0, 4'h0);
      check("republish_num",    num,         16'h5678);
      check("republish_pulses", 16'(pulses), 16'd5);

      anode    = 4'hF;
      sevenseg = 7'b1111111;
      repeat (4) @(negedge clk);
      check("queue_drained", 16'(exp_q.size()), 16'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
